// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle control sequencer: states, instruction
// classes, opcode/funct values and the datapath select codes.
package mc_pkg;

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_EXE    = 4'd2,
        ST_MEM_RD = 4'd3,
        ST_MEM_WR = 4'd4,
        ST_WB     = 4'd5,
        ST_BRANCH = 4'd6,
        ST_JUMP   = 4'd7,
        ST_HALT   = 4'd8
    } state_e;

    // R_ADDU sits at code 0 so that a cleared class register is all zeros.
    typedef enum logic [3:0] {
        R_ADDU = 4'd0,
        R_SUBU = 4'd1,
        ORI    = 4'd2,
        LUI    = 4'd3,
        LW     = 4'd4,
        SW     = 4'd5,
        BEQ    = 4'd6,
        J      = 4'd7,
        JAL    = 4'd8,
        ILL    = 4'd9
    } class_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;

    localparam logic [1:0] ALU_ADD  = 2'd0;
    localparam logic [1:0] ALU_SUB  = 2'd1;
    localparam logic [1:0] ALU_OR   = 2'd2;
    localparam logic [1:0] ALU_LUI  = 2'd3;

    localparam logic [1:0] EXT_ZERO  = 2'd0;
    localparam logic [1:0] EXT_SIGN  = 2'd1;
    localparam logic [1:0] EXT_UPPER = 2'd2;

    localparam logic [1:0] DST_RT   = 2'd0;
    localparam logic [1:0] DST_RD   = 2'd1;
    localparam logic [1:0] DST_RA   = 2'd2;

    localparam logic [1:0] WD_ALU   = 2'd0;
    localparam logic [1:0] WD_MDR   = 2'd1;
    localparam logic [1:0] WD_PC    = 2'd2;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: maps opcode/funct to one of the
// supported instruction classes, anything unrecognised becomes ILL.
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output class_e     cls
);

    // Classify the instruction; R-type only counts when funct is addu/subu.
    always_comb begin
        cls = ILL;
        case (op)
            OP_RTYPE: begin
                if (funct == FN_ADDU) begin
                    cls = R_ADDU;
                end else if (funct == FN_SUBU) begin
                    cls = R_SUBU;
                end
            end
            OP_ORI: cls = ORI;
            OP_LUI: cls = LUI;
            OP_LW:  cls = LW;
            OP_SW:  cls = SW;
            OP_BEQ: cls = BEQ;
            OP_J:   cls = J;
            OP_JAL: cls = JAL;
            default: cls = ILL;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control sequencer: steps each instruction through
// FETCH/DECODE/EXE/MEM/WB and drives Moore-style datapath strobes.
// The instruction class is captured when leaving DECODE so later states are
// immune to IR changes. Only the BRANCH pc_wr depends combinationally on zero.
module mc_ctrl
    import mc_pkg::*;
#(
    parameter logic [3:0] RESET_STATE = 4'd0
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    input  logic        zero,
    output logic        ir_wr,
    output logic        pc_wr,
    output logic        npc_sel,
    output logic        j_ctl,
    output logic        reg_wr,
    output logic [1:0]  reg_dst,
    output logic [1:0]  wd_sel,
    output logic        alu_src,
    output logic [1:0]  alu_op,
    output logic [1:0]  ext_op,
    output logic        mem_wr,
    output logic        halted,
    output logic [3:0]  state,
    output logic [31:0] instret
);

    state_e      state_q, state_d;
    class_e      class_q;
    class_e      dec_class;
    logic [31:0] instret_q, instret_d;

    mc_decode u_decode (
        .op    (op),
        .funct (funct),
        .cls   (dec_class)
    );

    // State, class and retire-count registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= state_e'(RESET_STATE);
            class_q   <= R_ADDU;
            instret_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
            if (state_q == ST_DECODE) begin
                class_q <= dec_class;
            end
        end
    end

    // Next-state and retire counting; the final state of every legal
    // instruction bumps the counter as it returns to FETCH.
    always_comb begin
        state_d   = ST_FETCH;
        instret_d = instret_q;
        case (state_q)
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: begin
                case (dec_class)
                    R_ADDU, R_SUBU, ORI, LUI, LW, SW: state_d = ST_EXE;
                    BEQ:                              state_d = ST_BRANCH;
                    J, JAL:                           state_d = ST_JUMP;
                    default:                          state_d = ST_HALT;
                endcase
            end
            ST_EXE: begin
                if (class_q == LW) begin
                    state_d = ST_MEM_RD;
                end else if (class_q == SW) begin
                    state_d = ST_MEM_WR;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM_RD: state_d = ST_WB;
            ST_MEM_WR, ST_WB, ST_BRANCH, ST_JUMP: begin
                state_d   = ST_FETCH;
                instret_d = instret_q + 32'd1;
            end
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_FETCH;
        endcase
    end

    // Moore output decode from the current state and registered class;
    // everything is forced low while reset is held.
    always_comb begin
        ir_wr   = 1'b0;
        pc_wr   = 1'b0;
        npc_sel = 1'b0;
        j_ctl   = 1'b0;
        reg_wr  = 1'b0;
        reg_dst = DST_RT;
        wd_sel  = WD_ALU;
        alu_src = 1'b0;
        alu_op  = ALU_ADD;
        ext_op  = EXT_ZERO;
        mem_wr  = 1'b0;
        halted  = 1'b0;
        if (!reset) begin
            case (state_q)
                ST_FETCH: begin
                    ir_wr = 1'b1;
                    pc_wr = 1'b1;
                end
                ST_EXE: begin
                    case (class_q)
                        R_SUBU: alu_op = ALU_SUB;
                        ORI: begin
                            alu_src = 1'b1;
                            alu_op  = ALU_OR;
                            ext_op  = EXT_ZERO;
                        end
                        LUI: begin
                            alu_src = 1'b1;
                            alu_op  = ALU_LUI;
                            ext_op  = EXT_UPPER;
                        end
                        LW, SW: begin
                            alu_src = 1'b1;
                            alu_op  = ALU_ADD;
                            ext_op  = EXT_SIGN;
                        end
                        default: alu_op = ALU_ADD;
                    endcase
                end
                ST_MEM_WR: mem_wr = 1'b1;
                ST_WB: begin
                    reg_wr  = 1'b1;
                    reg_dst = (class_q == R_ADDU || class_q == R_SUBU) ? DST_RD : DST_RT;
                    wd_sel  = (class_q == LW) ? WD_MDR : WD_ALU;
                end
                ST_BRANCH: begin
                    alu_op  = ALU_SUB;
                    npc_sel = 1'b1;
                    ext_op  = EXT_SIGN;
                    pc_wr   = zero;
                end
                ST_JUMP: begin
                    j_ctl = 1'b1;
                    pc_wr = 1'b1;
                    if (class_q == JAL) begin
                        reg_wr  = 1'b1;
                        reg_dst = DST_RA;
                        wd_sel  = WD_PC;
                    end
                end
                ST_HALT:  halted = 1'b1;
                default: ;
            endcase
        end
    end

    assign state   = reset ? 4'd0 : state_q;
    assign instret = reset ? 32'd0 : instret_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed self-checking bench for mc_ctrl: walks each instruction class
// through its state sequence and checks strobes, retire count and reset.
module tb_mc_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic        ir_wr, pc_wr, npc_sel, j_ctl, reg_wr, alu_src, mem_wr, halted;
    logic [1:0]  reg_dst, wd_sel, alu_op, ext_op;
    logic [3:0]  state;
    logic [31:0] instret;
    logic [15:0] obs;

    int compared   = 0;
    int mismatched = 0;

    mc_ctrl dut (
        .clk     (clk),
        .reset   (reset),
        .op      (op),
        .funct   (funct),
        .zero    (zero),
        .ir_wr   (ir_wr),
        .pc_wr   (pc_wr),
        .npc_sel (npc_sel),
        .j_ctl   (j_ctl),
        .reg_wr  (reg_wr),
        .reg_dst (reg_dst),
        .wd_sel  (wd_sel),
        .alu_src (alu_src),
        .alu_op  (alu_op),
        .ext_op  (ext_op),
        .mem_wr  (mem_wr),
        .halted  (halted),
        .state   (state),
        .instret (instret)
    );

    // 10-unit clock.
    always #5 clk = ~clk;

    assign obs = {ir_wr, pc_wr, npc_sel, j_ctl, reg_wr, reg_dst, wd_sel,
                  alu_src, alu_op, ext_op, mem_wr, halted};

    // Builds the expected strobe vector in the same field order as obs.
    function automatic logic [15:0] outs(input logic ir, input logic pc,
                                         input logic npc, input logic jc,
                                         input logic rw, input logic [1:0] rd,
                                         input logic [1:0] wd, input logic as,
                                         input logic [1:0] aop, input logic [1:0] ext,
                                         input logic mw, input logic h);
        return {ir, pc, npc, jc, rw, rd, wd, as, aop, ext, mw, h};
    endfunction

    localparam logic [15:0] NONE = 16'h0000;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic checkStep(input string tag, input logic [3:0] expState, input logic [15:0] expOuts);
        checkOutput({tag, ".state"}, {28'd0, state}, {28'd0, expState});
        checkOutput({tag, ".outs"}, {16'd0, obs}, {16'd0, expOuts});
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [5:0] o, input logic [5:0] f);
        op    = o;
        funct = f;
    endtask

    initial begin
        reset = 1'b1;
        op    = 6'd0;
        funct = 6'd0;
        zero  = 1'b0;
        tick();
        tick();
        checkStep("reset_hold", 4'd0, NONE);
        checkOutput("reset_instret", instret, 32'd0);

        // addu: 0,1,2,5,0
        applyStimulus(6'b000000, 6'b100001);
        reset = 1'b0;
        #1;
        checkStep("addu_fetch", 4'd0, outs(1,1,0,0,0,2'd0,2'd0,0,2'd0,2'd0,0,0));
        tick(); checkStep("addu_decode", 4'd1, NONE);
        tick(); checkStep("addu_exe", 4'd2, NONE);
        tick(); checkStep("addu_wb", 4'd5, outs(0,0,0,0,1,2'd1,2'd0,0,2'd0,2'd0,0,0));
        tick(); checkStep("addu_next", 4'd0, outs(1,1,0,0,0,2'd0,2'd0,0,2'd0,2'd0,0,0));
        checkOutput("addu_instret", instret, 32'd1);

        // lw: 0,1,2,3,5
        applyStimulus(6'b100011, 6'd0);
        tick(); checkStep("lw_decode", 4'd1, NONE);
        tick(); checkStep("lw_exe", 4'd2, outs(0,0,0,0,0,2'd0,2'd0,1,2'd0,2'd1,0,0));
        tick(); checkStep("lw_memrd", 4'd3, NONE);
        tick(); checkStep("lw_wb", 4'd5, outs(0,0,0,0,1,2'd0,2'd1,0,2'd0,2'd0,0,0));
        tick(); checkStep("lw_next", 4'd0, outs(1,1,0,0,0,2'd0,2'd0,0,2'd0,2'd0,0,0));

        // sw: 0,1,2,4
        applyStimulus(6'b101011, 6'd0);
        tick(); checkStep("sw_decode", 4'd1, NONE);
        tick(); checkStep("sw_exe", 4'd2, outs(0,0,0,0,0,2'd0,2'd0,1,2'd0,2'd1,0,0));
        tick(); checkStep("sw_memwr", 4'd4, outs(0,0,0,0,0,2'd0,2'd0,0,2'd0,2'd0,1,0));
        tick(); checkStep("sw_next", 4'd0, outs(1,1,0,0,0,2'd0,2'd0,0,2'd0,2'd0,0,0));
        checkOutput("lwsw_instret", instret, 32'd3);

        // beq taken, with zero toggled inside BRANCH
        applyStimulus(6'b000100, 6'd0);
        zero = 1'b1;
        tick(); checkStep("beq1_decode", 4'd1, NONE);
        tick(); checkStep("beq1_branch", 4'd6, outs(0,1,1,0,0,2'd0,2'd0,0,2'd1,2'd1,0,0));
        zero = 1'b0; #1;
        checkOutput("beq1_pcwr_z0", {31'd0, pc_wr}, 32'd0);
        zero = 1'b1; #1;
        checkOutput("beq1_pcwr_z1", {31'd0, pc_wr}, 32'd1);
        tick(); checkStep("beq1_next", 4'd0, outs(1,1,0,0,0,2'd0,2'd0,0,2'd0,2'd0,0,0));

        // beq not taken
        zero = 1'b0;
        tick(); checkStep("beq2_decode", 4'd1, NONE);
        tick(); checkStep("beq2_branch", 4'd6, outs(0,0,1,0,0,2'd0,2'd0,0,2'd1,2'd1,0,0));
        tick(); checkOutput("beq_instret", instret, 32'd5);

        // jal then j
        applyStimulus(6'b000011, 6'd0);
        tick(); tick();
        checkStep("jal_jump", 4'd7, outs(0,1,0,1,1,2'd2,2'd2,0,2'd0,2'd0,0,0));
        tick();
        applyStimulus(6'b000010, 6'd0);
        tick(); tick();
        checkStep("j_jump", 4'd7, outs(0,1,0,1,0,2'd0,2'd0,0,2'd0,2'd0,0,0));
        tick(); checkOutput("jump_instret", instret, 32'd7);

        // ori, lui, subu EXE decode
        applyStimulus(6'b001101, 6'd0);
        tick(); tick();
        checkStep("ori_exe", 4'd2, outs(0,0,0,0,0,2'd0,2'd0,1,2'd2,2'd0,0,0));
        tick(); checkStep("ori_wb", 4'd5, outs(0,0,0,0,1,2'd0,2'd0,0,2'd0,2'd0,0,0));
        tick();
        applyStimulus(6'b001111, 6'd0);
        tick(); tick();
        checkStep("lui_exe", 4'd2, outs(0,0,0,0,0,2'd0,2'd0,1,2'd3,2'd2,0,0));
        tick(); tick();
        applyStimulus(6'b000000, 6'b100011);
        tick(); tick();
        checkStep("subu_exe", 4'd2, outs(0,0,0,0,0,2'd0,2'd0,0,2'd1,2'd0,0,0));
        tick(); checkStep("subu_wb", 4'd5, outs(0,0,0,0,1,2'd1,2'd0,0,2'd0,2'd0,0,0));
        tick(); checkOutput("alu_instret", instret, 32'd10);

        // illegal opcode traps in HALT and stays there
        applyStimulus(6'b111111, 6'd0);
        tick(); checkStep("ill1_decode", 4'd1, NONE);
        for (int i = 0; i < 20; i++) begin
            tick();
            checkStep("ill1_halt", 4'd8, outs(0,0,0,0,0,2'd0,2'd0,0,2'd0,2'd0,0,1));
        end
        checkOutput("ill1_instret", instret, 32'd10);
        reset = 1'b1; #1;
        checkStep("ill1_reset_comb", 4'd0, NONE);
        tick();
        reset = 1'b0; #1;
        checkStep("ill1_recover", 4'd0, outs(1,1,0,0,0,2'd0,2'd0,0,2'd0,2'd0,0,0));
        checkOutput("ill1_rst_instret", instret, 32'd0);

        // R-type with unsupported funct is illegal too
        applyStimulus(6'b000000, 6'b000000);
        tick(); tick();
        checkStep("ill2_halt", 4'd8, outs(0,0,0,0,0,2'd0,2'd0,0,2'd0,2'd0,0,1));
        reset = 1'b1;
        tick();
        reset = 1'b0; #1;
        checkStep("ill2_recover", 4'd0, outs(1,1,0,0,0,2'd0,2'd0,0,2'd0,2'd0,0,0));

        // sw retires once, then reset during the next sw's MEM_WR
        applyStimulus(6'b101011, 6'd0);
        tick(); tick(); tick(); tick();
        checkOutput("sw_pre_instret", instret, 32'd1);
        tick(); tick(); tick();
        checkStep("swr_memwr", 4'd4, outs(0,0,0,0,0,2'd0,2'd0,0,2'd0,2'd0,1,0));
        reset = 1'b1; #1;
        checkOutput("swr_memwr_suppr", {31'd0, mem_wr}, 32'd0);
        tick();
        reset = 1'b0; #1;
        checkStep("swr_after", 4'd0, outs(1,1,0,0,0,2'd0,2'd0,0,2'd0,2'd0,0,0));
        checkOutput("swr_instret", instret, 32'd0);

        // IR changes after DECODE must not affect EXE or the path taken
        applyStimulus(6'b100011, 6'd0);
        tick();
        tick();
        applyStimulus(6'b001101, 6'd0);
        #1;
        checkStep("latch_exe", 4'd2, outs(0,0,0,0,0,2'd0,2'd0,1,2'd0,2'd1,0,0));
        tick(); checkStep("latch_memrd", 4'd3, NONE);
        tick(); checkStep("latch_wb", 4'd5, outs(0,0,0,0,1,2'd0,2'd1,0,2'd0,2'd0,0,0));
        tick(); checkOutput("latch_instret", instret, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
